ntt_butterfly: RTL and testbench
================================

Name: ntt_butterfly

Overview:
- Pipelined radix-2 butterfly for the Kyber NTT/INTT datapath (q=3329), sitting directly downstream of the modular arithmetic primitives mod_add, mod_sub and montgomery_mult.
- Accepts one coefficient pair plus a twiddle factor per cycle.
- Computes a Cooley-Tukey (forward) or Gentleman-Sande (inverse) butterfly.
- Returns the result pair, with a passthrough index, over a valid/ready handshake. Consumer is the NTT controller / coefficient RAM write-back.

Parameters:
- DWIDTH, 12 (from defines.vh): coefficient width.
- Q, 3329 (from defines.vh): Kyber modulus.
- IDX_W, 8: width of the opaque tag carried alongside each butterfly.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept this cycle
- in_mode  in  1  0 = CT forward, 1 = GS inverse
- in_a  in  DWIDTH  coefficient a, guaranteed < Q
- in_b  in  DWIDTH  coefficient b, guaranteed < Q
- in_zeta  in  DWIDTH  twiddle, Montgomery form (zeta·2^16 mod Q), < Q
- in_idx  in  IDX_W  tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts this cycle
- out_a  out  DWIDTH  result a'
- out_b  out  DWIDTH  result b'
- out_idx  out  IDX_W  tag of this result
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Arithmetic uses the existing primitives:
  - add(x,y) = (x+y) mod Q
  - sub(x,y) = (x−y) mod Q
  - mont(x,y) = x·y·2^-16 mod Q, i.e. x·y·169 mod Q; all results in [0,Q−1].
- CT (mode 0):
  - t = mont(b, zeta)
  - a' = add(a, t)
  - b' = sub(a, t)
- GS (mode 1):
  - a' = add(a, b)
  - b' = mont(sub(a, b), zeta)
- Pipeline stages, each with its own valid bit; mode and idx travel with the data:
  - S1: registered inputs.
  - S2: first operation. CT registers t plus a; GS registers a' plus the difference.
  - S3 (output registers): second operation.
- Latency: pair accepted on edge k appears on out_* with out_valid=1 after edge k+2. Throughput 1 butterfly/cycle with no stall.
- Handshake:
  - Input transfer on an edge with in_valid & in_ready.
  - Output transfer on an edge with out_valid & out_ready.
  - out_* hold stable while out_valid=1 & out_ready=0.
- Stall: stage i loads when stage i is empty or stage i+1 loads; S3 loads when !out_valid | out_ready.
  - in_ready = !S1.valid | S1_loads. It is combinational from out_ready through the chain; no registered skid.
  - Max 3 butterflies in flight. Bubbles collapse, so a stalled pipeline fills completely before in_ready drops.
- Simultaneous output and input transfers in the same cycle with a full pipeline are legal and lose nothing.
- Order preserved: out_idx sequence equals in_idx acceptance sequence.
- Reset (rst=1 at an edge, including mid-operation):
  - All valid bits clear; in-flight data is discarded.
  - Outputs after that edge: out_valid=0, out_a=0, out_b=0, out_idx=0, busy=0.
  - in_ready=1 while rst is low after reset. in_ready=0 during any cycle rst is high.
- busy = S1.valid | S2.valid | out_valid.
- Inputs ≥ Q are outside contract; no checking logic is implemented.

Decomposition:
- defines.vh holds DWIDTH, Q, the Montgomery constants (R=2^16, R^-1 mod Q = 169, R mod Q = 2285) and the mode encodings (MODE_CT=0, MODE_GS=1).
- Reuse mod_add, mod_sub and montgomery_mult as instances.
- One natural sub-module: bfly_pipe_stage, a generic valid/stall register slice parameterised by payload width. Instantiate it three times.

Test Plan:
1. CT, zeta=2285 (mont identity), a=100, b=200, idx=5 → after edge k+2: out_a=300, out_b=3229, out_idx=5.
2. GS, zeta=2285, a=3300, b=100 → out_a=71, out_b=3200. Then GS, zeta=2285, a=0, b=1 → out_a=1, out_b=3328.
3. CT, zeta=1, a=0, b=20 → t=51, so out_a=51, out_b=3278. Also CT, zeta=0, a=500, b=200 → out_a=500, out_b=500.
4. Backpressure: 6 back-to-back CT pairs with idx 0..5, out_ready low from the first out_valid for 4 cycles → in_ready falls after 3 held; all 6 outputs emerge in order 0..5 with no duplicates; out_* stable while stalled.
5. Reset mid-flight: 2 pairs accepted, rst high for one edge → following cycle out_valid=0, busy=0, out_a/out_b/out_idx=0, in_ready=1; no stale output ever appears.
6. 2000 random legal vectors, random mode, random in_valid/out_ready → every output matches the golden model for both modes, and the count and order match the inputs.

Source files
------------

// File: rtl/ntt_butterfly_pkg.sv
// Shared types and constants for the Kyber NTT/INTT butterfly.
//   DWIDTH   coefficient width
//   Q        Kyber modulus
//   IDX_W    width of the opaque tag carried with each butterfly
// Montgomery form uses R = 2^16; MONT_QINV_NEG = -Q^-1 mod R.
package ntt_butterfly_pkg;

  localparam int DWIDTH      = 12;
  localparam int Q           = 3329;
  localparam int IDX_W       = 8;
  localparam int MONT_R_BITS = 16;
  localparam logic [MONT_R_BITS-1:0] MONT_QINV_NEG = 16'd3327;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } bfly_mode_e;

  typedef logic [DWIDTH-1:0] coef_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // S1: raw registered inputs
  typedef struct packed {
    bfly_mode_e mode;
    coef_t      a;
    coef_t      b;
    coef_t      zeta;
    idx_t       idx;
  } s1_payload_t;

  // S2: CT holds {x=a, y=t}; GS holds {x=a', y=a-b}
  typedef struct packed {
    bfly_mode_e mode;
    coef_t      x;
    coef_t      y;
    coef_t      zeta;
    idx_t       idx;
  } s2_payload_t;

  // S3: final result
  typedef struct packed {
    coef_t a;
    coef_t b;
    idx_t  idx;
  } s3_payload_t;

endpackage

// File: rtl/ntt_butterfly_if.sv
// Handshake/data bundle for ntt_butterfly.
//   in_*      request side: valid/ready, mode, a, b, zeta, idx
//   out_*     result side: valid/ready, a', b', idx
//   busy      any pipeline stage holds valid data
// master = producer/consumer side (testbench, controller); slave = butterfly.
interface ntt_butterfly_if;
  import ntt_butterfly_pkg::*;

  logic  in_valid;
  logic  in_ready;
  logic  in_mode;
  coef_t in_a;
  coef_t in_b;
  coef_t in_zeta;
  idx_t  in_idx;
  logic  out_valid;
  logic  out_ready;
  coef_t out_a;
  coef_t out_b;
  idx_t  out_idx;
  logic  busy;

  modport master (
    output in_valid, in_mode, in_a, in_b, in_zeta, in_idx, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_idx, busy
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_zeta, in_idx, out_ready,
    output in_ready, out_valid, out_a, out_b, out_idx, busy
  );

endinterface

// File: rtl/ntt_butterfly_arith.sv
// Combinational modular primitives over Z_Q, all operands/results in [0,Q-1].
//   mod_add          z = (x + y) mod Q
//   mod_sub          z = (x - y) mod Q
//   montgomery_mult  z = x * y * 2^-16 mod Q
module mod_add
  import ntt_butterfly_pkg::*;
(
  input  coef_t x,
  input  coef_t y,
  output coef_t z
);
  localparam logic [DWIDTH:0] Q_EXT = (DWIDTH+1)'(Q);

  logic [DWIDTH:0] sum;
  logic [DWIDTH:0] red;

  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    red = sum - Q_EXT;
    z   = (sum >= Q_EXT) ? red[DWIDTH-1:0] : sum[DWIDTH-1:0];
  end
endmodule

module mod_sub
  import ntt_butterfly_pkg::*;
(
  input  coef_t x,
  input  coef_t y,
  output coef_t z
);
  localparam logic [DWIDTH:0] Q_EXT = (DWIDTH+1)'(Q);

  logic [DWIDTH:0] diff;
  logic [DWIDTH:0] wrap;

  // Borrow out of the top bit means x < y; adding Q back lands in [1,Q-1].
  always_comb begin
    diff = {1'b0, x} - {1'b0, y};
    wrap = diff + Q_EXT;
    z    = diff[DWIDTH] ? wrap[DWIDTH-1:0] : diff[DWIDTH-1:0];
  end
endmodule

module montgomery_mult
  import ntt_butterfly_pkg::*;
(
  input  coef_t x,
  input  coef_t y,
  output coef_t z
);
  localparam int PW = 2 * DWIDTH;
  localparam logic [MONT_R_BITS-1:0] Q_R   = MONT_R_BITS'(Q);
  localparam logic [31:0]            Q_32  = 32'(Q);

  logic [PW-1:0]          prod;
  logic [MONT_R_BITS-1:0] m;
  logic [31:0]            acc;
  logic [MONT_R_BITS-1:0] t;

  // REDC: m makes prod + m*Q divisible by 2^16; the quotient is < 2Q so a
  // single conditional subtract finishes the reduction.
  always_comb begin
    prod = {{DWIDTH{1'b0}}, x} * {{DWIDTH{1'b0}}, y};
    m    = prod[MONT_R_BITS-1:0] * MONT_QINV_NEG;
    acc  = {{(32-PW){1'b0}}, prod} + ({16'b0, m} * Q_32);
    t    = acc[31:MONT_R_BITS];
    z    = (t >= Q_R) ? DWIDTH'(t - Q_R) : t[DWIDTH-1:0];
  end
endmodule

// File: rtl/ntt_butterfly_stage.sv
// bfly_pipe_stage: one valid/stall register slice of the butterfly pipeline.
//   in_valid/in_data/in_ready     upstream side
//   out_valid/out_data/out_ready  downstream side (out_ready = next slice loads)
// The slice loads whenever it is empty or downstream takes its content, so
// bubbles collapse. Data only changes on a real transfer, keeping outputs
// stable while stalled.
module bfly_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: pipelined radix-2 Kyber butterfly (q = 3329).
//   clk, rst   clock, synchronous active-high reset
//   bus        ntt_butterfly_if.slave: in_* request, out_* result, busy
// CT (mode 0): t = mont(b,zeta); a' = a+t; b' = a-t
// GS (mode 1): a' = a+b;         b' = mont(a-b, zeta)
// S1 registers inputs, S2 the first operation, S3 the second (outputs).
// Latency 2 edges after acceptance, one butterfly per cycle.
module ntt_butterfly
  import ntt_butterfly_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ntt_butterfly_if.slave bus
);
  s1_payload_t s1_in, s1_q;
  s2_payload_t s2_in, s2_q;
  s3_payload_t s3_in, s3_q;
  logic        s1_ready, s2_ready, s3_ready;
  logic        s1_valid, s2_valid, s3_valid;

  coef_t t_ct, sum_ab, diff_ab;
  coef_t sum_xy, diff_xy, t_gs;

  always_comb begin
    s1_in.mode = bfly_mode_e'(bus.in_mode);
    s1_in.a    = bus.in_a;
    s1_in.b    = bus.in_b;
    s1_in.zeta = bus.in_zeta;
    s1_in.idx  = bus.in_idx;
  end

  bfly_pipe_stage #(.W($bits(s1_payload_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   (s1_in),
    .in_ready  (s1_ready),
    .out_valid (s1_valid),
    .out_data  (s1_q),
    .out_ready (s2_ready)
  );

  montgomery_mult u_mont_ct (.x(s1_q.b), .y(s1_q.zeta), .z(t_ct));
  mod_add         u_add_ab  (.x(s1_q.a), .y(s1_q.b),    .z(sum_ab));
  mod_sub         u_sub_ab  (.x(s1_q.a), .y(s1_q.b),    .z(diff_ab));

  always_comb begin
    s2_in.mode = s1_q.mode;
    s2_in.zeta = s1_q.zeta;
    s2_in.idx  = s1_q.idx;
    if (s1_q.mode == MODE_GS) begin
      s2_in.x = sum_ab;
      s2_in.y = diff_ab;
    end else begin
      s2_in.x = s1_q.a;
      s2_in.y = t_ct;
    end
  end

  bfly_pipe_stage #(.W($bits(s2_payload_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   (s2_in),
    .in_ready  (s2_ready),
    .out_valid (s2_valid),
    .out_data  (s2_q),
    .out_ready (s3_ready)
  );

  mod_add         u_add_xy  (.x(s2_q.x), .y(s2_q.y),    .z(sum_xy));
  mod_sub         u_sub_xy  (.x(s2_q.x), .y(s2_q.y),    .z(diff_xy));
  montgomery_mult u_mont_gs (.x(s2_q.y), .y(s2_q.zeta), .z(t_gs));

  always_comb begin
    s3_in.idx = s2_q.idx;
    if (s2_q.mode == MODE_GS) begin
      s3_in.a = s2_q.x;
      s3_in.b = t_gs;
    end else begin
      s3_in.a = sum_xy;
      s3_in.b = diff_xy;
    end
  end

  bfly_pipe_stage #(.W($bits(s3_payload_t))) u_s3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s2_valid),
    .in_data   (s3_in),
    .in_ready  (s3_ready),
    .out_valid (s3_valid),
    .out_data  (s3_q),
    .out_ready (bus.out_ready)
  );

  // in_ready is forced low while reset is asserted so nothing is accepted
  // on the reset edge.
  assign bus.in_ready  = s1_ready && !rst;
  assign bus.out_valid = s3_valid;
  assign bus.out_a     = s3_q.a;
  assign bus.out_b     = s3_q.b;
  assign bus.out_idx   = s3_q.idx;
  assign bus.busy      = s1_valid || s2_valid || s3_valid;
endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed vector table, latency,
// backpressure, mid-flight reset and a randomised handshake stream.
module tb_ntt_butterfly;
  import ntt_butterfly_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_butterfly_if bif ();
  ntt_butterfly dut (.clk(clk), .rst(rst), .bus(bif));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic mode;
    int   a, b, zeta, idx;
    int   ea, eb;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int m_add(int x, int y); return (x + y) % 3329; endfunction
  function automatic int m_sub(int x, int y); return (x - y + 3329) % 3329; endfunction
  function automatic int m_mont(int x, int y); return (x * y * 169) % 3329; endfunction

  function automatic vec_t make_item(int i, bit rnd);
    vec_t v;
    int t;
    if (rnd) begin
      v.mode = 1'($urandom_range(0, 1));
      v.a    = $urandom_range(0, 3328);
      v.b    = $urandom_range(0, 3328);
      v.zeta = $urandom_range(0, 3328);
    end else begin
      v.mode = 1'b0;
      v.a    = (i * 300 + 11) % 3329;
      v.b    = (i * 500 + 7) % 3329;
      v.zeta = 1000;
    end
    v.idx = i % 256;
    if (v.mode == 1'b0) begin
      t    = m_mont(v.b, v.zeta);
      v.ea = m_add(v.a, t);
      v.eb = m_sub(v.a, t);
    end else begin
      v.ea = m_add(v.a, v.b);
      v.eb = m_mont(m_sub(v.a, v.b), v.zeta);
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bif.in_mode = v.mode;
    bif.in_a    = v.a[DWIDTH-1:0];
    bif.in_b    = v.b[DWIDTH-1:0];
    bif.in_zeta = v.zeta[DWIDTH-1:0];
    bif.in_idx  = v.idx[IDX_W-1:0];
  endtask

  // Cycle-accurate stream with a scoreboard queue. rnd=0: six CT pairs with
  // out_ready held low for the first 4 cycles of out_valid.
  task automatic run_stream(input int n, input bit rnd, input int budget);
    vec_t cur, exp_v;
    vec_t q[$];
    int sent = 0, recv = 0, stall_cnt = 0;
    bit drop_seen = 0, prev_stall = 0;
    int pa = 0, pb = 0, pi = 0;
    cur = make_item(0, rnd);
    for (int cyc = 0; cyc < budget && recv < n; cyc++) begin
      @(posedge clk); #1;
      if (sent < n) begin
        bif.in_valid = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
        drive(cur);
      end else begin
        bif.in_valid = 1'b0;
      end
      bif.out_ready = rnd ? ($urandom_range(0, 9) < 7) : (stall_cnt >= 4);
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", int'(bif.out_valid), 1);
        chk("hold_a", int'(bif.out_a), pa);
        chk("hold_b", int'(bif.out_b), pb);
        chk("hold_idx", int'(bif.out_idx), pi);
      end
      if (bif.out_valid && bif.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", int'(bif.out_idx), -1);
        end else begin
          exp_v = q.pop_front();
          chk("stream_a", int'(bif.out_a), exp_v.ea);
          chk("stream_b", int'(bif.out_b), exp_v.eb);
          chk("stream_idx", int'(bif.out_idx), exp_v.idx);
        end
        recv++;
      end
      if (bif.in_valid && bif.in_ready) begin
        q.push_back(cur);
        sent++;
        cur = make_item(sent, rnd);
      end
      if (!rnd && !drop_seen && !bif.in_ready && sent < n) begin
        drop_seen = 1;
        chk("accepted_before_stall", sent, 3);
      end
      if (!rnd && bif.out_valid && !bif.out_ready) stall_cnt++;
      prev_stall = bif.out_valid && !bif.out_ready;
      pa = int'(bif.out_a);
      pb = int'(bif.out_b);
      pi = int'(bif.out_idx);
    end
    chk("stream_count", recv, n);
    chk("stream_leftover", q.size(), 0);
    if (!rnd) chk("in_ready_dropped", int'(drop_seen), 1);
    @(posedge clk); #1;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_idle_busy", int'(bif.busy), 0);
  endtask

  vec_t tbl[10];

  initial begin
    // mode a b zeta idx exp_a exp_b
    tbl[0] = '{1'b0,  100,  200, 2285,   5,  300, 3229};
    tbl[1] = '{1'b1, 3300,  100, 2285,   6,   71, 3200};
    tbl[2] = '{1'b1,    0,    1, 2285,   7,    1, 3328};
    tbl[3] = '{1'b0,    0,   20,    1,   8,   51, 3278};
    tbl[4] = '{1'b0,  500,  200,    0,   9,  500,  500};
    tbl[5] = '{1'b0, 3328, 3328, 2285,  10, 3327,    0};
    tbl[6] = '{1'b1,   10,    4,    1,  11,   14, 1014};
    tbl[7] = '{1'b0,    0,    0, 2285, 255,    0,    0};
    tbl[8] = '{1'b1,    5,    7,    0, 128,   12,    0};
    tbl[9] = '{1'b1, 3328, 3328, 2285,   1, 3327,    0};

    rst = 1'b1;
    bif.in_valid = 1'b0; bif.out_ready = 1'b0;
    bif.in_mode = 1'b0; bif.in_a = '0; bif.in_b = '0; bif.in_zeta = '0; bif.in_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", int'(bif.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(bif.out_valid), 0);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_in_ready", int'(bif.in_ready), 1);
    chk("rst_out_a", int'(bif.out_a), 0);
    chk("rst_out_idx", int'(bif.out_idx), 0);

    // Directed vectors, one at a time, checking exact two-edge latency.
    bif.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bif.in_valid = 1'b1;
      drive(tbl[i]);
      @(negedge clk);
      chk("vec_in_ready", int'(bif.in_ready), 1);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat_k", int'(bif.out_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("vec_lat_k1", int'(bif.out_valid), 0);
      chk("vec_busy_mid", int'(bif.busy), 1);
      @(posedge clk);
      @(negedge clk);
      chk("vec_out_valid", int'(bif.out_valid), 1);
      chk("vec_out_a", int'(bif.out_a), tbl[i].ea);
      chk("vec_out_b", int'(bif.out_b), tbl[i].eb);
      chk("vec_out_idx", int'(bif.out_idx), tbl[i].idx);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("vec_drained", int'(bif.out_valid), 0);

    // Backpressure with a full pipeline.
    run_stream(6, 1'b0, 60);

    // Reset with two pairs in flight.
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    drive(tbl[0]);
    @(posedge clk); #1;
    drive(tbl[1]);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", int'(bif.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(bif.out_valid), 0);
    chk("midrst_busy", int'(bif.busy), 0);
    chk("midrst_out_a", int'(bif.out_a), 0);
    chk("midrst_out_b", int'(bif.out_b), 0);
    chk("midrst_out_idx", int'(bif.out_idx), 0);
    chk("midrst_in_ready", int'(bif.in_ready), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_stale", int'(bif.out_valid), 0);
    end

    // Random legal traffic in both modes.
    run_stream(2000, 1'b1, 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
